conv_stream_engine: RTL and testbench
=====================================

Name: conv_stream_engine

Overview:
Parametrised streaming 2-D convolution layer for the LeNet accelerator. It accepts one input feature map as a row-major pixel stream with a valid/ready handshake and holds a K×K window in line buffers. Each complete window produces OUT_CH convolution results in parallel, with optional ReLU and signed saturation. It generalises the fixed 28×28 / 5×5 / 32-bit conv stages to configurable image size, kernel size, channel count and data width, and adds weight loading and back-pressure.

Parameters:
DATA_W, 16, signed width of pixels, weights and outputs.
IMG_W, 28, input row length in pixels (must be >= K).
IMG_H, 28, input row count (must be >= K).
K, 5, square kernel edge (>= 2).
OUT_CH, 2, number of output channels computed in parallel.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: begin a frame; ignored unless IDLE.
relu_en  in  1  sampled on accepted start; clamps negative results to 0 for the frame.
busy  out  1  high while not IDLE.
done  out  1  one-cycle pulse after the last output handshake.
w_we  in  1  weight write strobe.
w_ch  in  clog2(OUT_CH) (min 1)  weight channel.
w_idx  in  clog2(K*K)  weight index, row*K+col.
w_data  in  DATA_W  signed weight value.
in_valid  in  1  input pixel valid.
in_ready  out  1  input pixel accepted when in_valid && in_ready.
in_data  in  DATA_W  signed pixel.
out_valid  out  1  result valid.
out_ready  in  1  downstream ready.
out_data  out  OUT_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
out_last  out  1  high with the final result of the frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, in_ready, out_valid, out_last = 0; out_data = 0; pixel counters = 0. Weights and line buffers are not reset. Reset mid-frame abandons the frame, with no done pulse.
- Weights: with w_we=1 in IDLE, the weight is written on the clock edge. In RUN or DRAIN, w_we is ignored. Weights persist across frames.
- FSM:
  - IDLE -> RUN on start (relu_en latched, counters cleared).
  - RUN -> DRAIN on acceptance of pixel IMG_W*IMG_H-1.
  - DRAIN -> IDLE when the final out_valid && out_ready handshake occurs; done=1 in the following cycle.
  - A start pulse outside IDLE is ignored.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational from registered state and out_ready.
- Each accepted pixel at (r,c) shifts into the window, and into a line buffer of K-1 rows × IMG_W.
- If r>=K-1 and c>=K-1, a result for out(r-K+1, c-K+1) is registered. out_valid rises on the next edge, a latency of 1 cycle after acceptance.
- Per channel ch: out(i,j) = sum over u,v < K of w[ch][u*K+v] * img[i+u][j+v].
  - Products are 2*DATA_W signed.
  - The accumulator is 2*DATA_W+clog2(K*K) bits, with no intermediate overflow.
  - The result is ReLU'd if enabled, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- While out_valid && !out_ready: out_data and out_last hold stable and in_ready=0, so no pixels are lost. Throughput is one pixel per cycle under continuous valid/ready.
- Outputs per frame: (IMG_H-K+1)*(IMG_W-K+1). out_last is asserted only with the final one.
- Window columns do not wrap across rows. Windows whose span crosses the end of a row produce no output.
- Simultaneous out handshake and new result in the same cycle: the register is reloaded and out_valid stays 1.

Decomposition:
- Package conv_stream_pkg holds:
  - state enum typedef {IDLE, RUN, DRAIN};
  - the accumulator-width function ACC_W(DATA_W,K);
  - the saturate/ReLU function.
- Sub-module conv_line_buffer (parameters DATA_W, IMG_W, K) owns the K-1 row FIFOs and the K×K window shift registers. Its outputs are the flattened window plus window_valid.
- The top level holds the FSM, counters, weight array, MAC trees and output register.

Test Plan:
- Impulse (defaults; DATA_W=16): img[0][0]=1, other pixels 0; w[0][0]=1, other weights 0. Required response: 576 outputs; ch0 out(0,0)=1; all other ch0 results and all ch1 results = 0; out_last on output 575; one done pulse.
- Identity shift (IMG 8×8, K=3): img[r][c]=r*8+c; w[1][4]=1. Required response: ch1 out(i,j) = (i+1)*8+(j+1), i.e. 36 outputs 9..54 (skipping row ends); ch0 = 0.
- Saturation/ReLU (K=3): all pixels 200, all ch0 weights 200 → 32767; all ch1 weights -200 → -32768. Repeat with relu_en=1: ch1 = 0 and ch0 is still 32767.
- Back-pressure: out_ready held low for 5 cycles at output 3. Required response: out_data stable and in_ready=0 for those cycles; the full result sequence is identical to the no-stall run.
- Weight write during RUN (w_we=1, w_data=7) is ignored: the next frame reproduces the previous results. A start pulse during RUN is ignored.
- Reset mid-frame: rst_n low after 20 pixels gives out_valid=0 and busy=0 immediately, with no done pulse. A fresh frame then matches the golden model.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Working width for the clamp helper; wide enough for any accumulator
    // with DATA_W up to about 28 bits.
    localparam int SAT_W = 64;

    // Accumulator width: a full-precision product plus one bit per doubling
    // of the number of taps, so a K*K sum can never overflow.
    function automatic int ACC_W(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k);
    endfunction

    // Optional ReLU followed by signed clamp to a data_w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int                      data_w,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        r  = v;
        if (relu && (v < 0)) begin
            r = '0;
        end
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffers plus a KxK window of shift registers for a row-major stream.
// Latency: window output is combinational from the pixel being accepted this cycle.
// Backpressure: none internally; the caller only strobes in_vld on an accepted pixel.
module conv_line_buffer
    import conv_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int K      = 5
) (
    input  logic                        clk,
    input  logic                        in_vld,
    input  logic [DATA_W-1:0]           in_dat,
    input  logic [$clog2(IMG_W)-1:0]    in_col,
    input  logic                        row_full,
    output logic [K*K*DATA_W-1:0]       window_dat,
    output logic                        window_vld
);

    localparam int COL_W = $clog2(IMG_W);

    // line_q[k][c] holds the pixel from k+1 rows above the current one at column c.
    logic [DATA_W-1:0] line_q [K-1][IMG_W];
    logic [DATA_W-1:0] col_vec [K];
    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];

    // New window column: oldest row at index 0, incoming pixel at index K-1.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            col_vec[k] = '0;
        end
        col_vec[K-1] = in_dat;
        for (int k = 0; k < K - 1; k++) begin
            col_vec[K-2-k] = line_q[k][in_col];
        end
    end

    // Window shifts left by one column and takes the new column on the right.
    always_comb begin
        for (int u = 0; u < K; u++) begin
            win_d[u][K-1] = col_vec[u];
            for (int v = 0; v < K - 1; v++) begin
                win_d[u][v] = win_q[u][v+1];
            end
        end
    end

    // Each row buffer hands its old entry one row further up as the new pixel lands.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            line_q[0][in_col] <= in_dat;
            for (int k = 1; k < K - 1; k++) begin
                line_q[k][in_col] <= line_q[k-1][in_col];
            end
        end
    end

    // Window registers advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            win_q <= win_d;
        end
    end

    // Flatten the post-shift window, element u*K+v.
    always_comb begin
        window_dat = '0;
        for (int u = 0; u < K; u++) begin
            for (int v = 0; v < K; v++) begin
                window_dat[(u*K+v)*DATA_W +: DATA_W] = win_d[u][v];
            end
        end
    end

    // A window is complete only once K rows and K columns of the current row are in.
    assign window_vld = in_vld && row_full && (in_col >= COL_W'(K - 1));

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution producing OUT_CH channels per window, with ReLU/saturation.
// Latency: one cycle from acceptance of a window-completing pixel to out_valid.
// Backpressure: in_ready drops while a result is held and out_ready is low; nothing is lost.
module conv_stream_engine
    import conv_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int OUT_CH = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         relu_en,
    output logic                                         busy,
    output logic                                         done,
    input  logic                                         w_we,
    input  logic [((OUT_CH > 1) ? $clog2(OUT_CH) : 1)-1:0] w_ch,
    input  logic [$clog2(K*K)-1:0]                       w_idx,
    input  logic [DATA_W-1:0]                            w_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_W-1:0]                            in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [OUT_CH*DATA_W-1:0]                     out_data,
    output logic                                         out_last
);

    localparam int NW    = K * K;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int AW    = ACC_W(DATA_W, K);

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic                       relu_q, relu_d;
    logic                       out_vld_q, out_vld_d;
    logic [OUT_CH*DATA_W-1:0]   out_dat_q, out_dat_d;
    logic                       out_last_q, out_last_d;
    logic                       done_q, done_d;

    logic signed [DATA_W-1:0]   wgt_q [OUT_CH][NW];

    logic                       pix_acc;
    logic                       last_col;
    logic                       last_row;
    logic                       row_full;
    logic [NW*DATA_W-1:0]       window_dat;
    logic                       window_vld;

    logic signed [AW-1:0]       acc_sum [OUT_CH];
    logic signed [DATA_W-1:0]   pix_e;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SAT_W-1:0]    acc_wide;
    logic signed [SAT_W-1:0]    acc_sat;
    logic [OUT_CH*DATA_W-1:0]   res_dat;

    assign in_ready = (state_q == RUN) && (!out_vld_q || out_ready);
    assign pix_acc  = in_valid && in_ready;
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    assign row_full = (row_q >= ROW_W'(K - 1));

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) u_line_buffer (
        .clk        (clk),
        .in_vld     (pix_acc),
        .in_dat     (in_data),
        .in_col     (col_q),
        .row_full   (row_full),
        .window_dat (window_dat),
        .window_vld (window_vld)
    );

    // Weight store: writable only while idle so a running frame sees constant taps.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && w_we && (int'(w_ch) < OUT_CH) && (int'(w_idx) < NW)) begin
            wgt_q[w_ch][w_idx] <= w_data;
        end
    end

    // Full-precision multiply-accumulate over the window for every channel.
    always_comb begin
        pix_e = '0;
        prod  = '0;
        for (int ch = 0; ch < OUT_CH; ch++) begin
            acc_sum[ch] = '0;
            for (int i = 0; i < NW; i++) begin
                pix_e       = window_dat[i*DATA_W +: DATA_W];
                prod        = wgt_q[ch][i] * pix_e;
                acc_sum[ch] = acc_sum[ch] + AW'(prod);
            end
        end
    end

    // Apply frame ReLU setting and clamp each channel to DATA_W.
    always_comb begin
        acc_wide = '0;
        acc_sat  = '0;
        res_dat  = '0;
        for (int ch = 0; ch < OUT_CH; ch++) begin
            acc_wide = SAT_W'(acc_sum[ch]);
            acc_sat  = sat_relu(acc_wide, DATA_W, relu_q);
            res_dat[ch*DATA_W +: DATA_W] = acc_sat[DATA_W-1:0];
        end
    end

    // Frame sequencing, pixel position counters and the output holding register.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        relu_d     = relu_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    relu_d  = relu_en;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (pix_acc) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + 1'b1;
                        if (last_row) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_vld_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new result always wins; in_ready guarantees the old one was consumed.
        if (window_vld) begin
            out_vld_d  = 1'b1;
            out_dat_d  = res_dat;
            out_last_d = last_col && last_row;
        end else if (out_ready) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            relu_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            relu_q     <= relu_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine on an 8x8 image with a 3x3 kernel.
// Latency: checks one-cycle result latency and done timing.
// Backpressure: exercises out_ready stalls and input gaps.
module tb_conv_stream_engine;

    localparam int DW   = 16;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int KK   = 3;
    localparam int NCH  = 2;
    localparam int NPIX = IW * IH;
    localparam int NOUT = (IH - KK + 1) * (IW - KK + 1);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               relu_en;
    logic               busy;
    logic               done;
    logic               w_we;
    logic [0:0]         w_ch;
    logic [3:0]         w_idx;
    logic [DW-1:0]      w_data;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NCH*DW-1:0]  out_data;
    logic               out_last;

    int                 n_tests;
    int                 n_fail;
    int                 img [IH][IW];
    int                 wm  [NCH][KK*KK];
    logic [NCH*DW:0]    exp_q [$];

    conv_stream_engine #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH),
        .K      (KK),
        .OUT_CH (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .w_we      (w_we),
        .w_ch      (w_ch),
        .w_idx     (w_idx),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int sat_model(input longint s, input bit relu);
        longint t;
        t = s;
        if (relu && t < 0) t = 0;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return int'(t);
    endfunction

    task automatic push_golden(input bit relu);
        logic [NCH*DW:0] e;
        longint s;
        int v;
        exp_q.delete();
        for (int i = 0; i <= IH - KK; i++) begin
            for (int j = 0; j <= IW - KK; j++) begin
                e = '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    s = 0;
                    for (int u = 0; u < KK; u++)
                        for (int v2 = 0; v2 < KK; v2++)
                            s += longint'(wm[ch][u*KK+v2]) * longint'(img[i+u][j+v2]);
                    v = sat_model(s, relu);
                    e[ch*DW +: DW] = DW'(v);
                end
                e[NCH*DW] = (i == IH - KK) && (j == IW - KK);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_weights();
        for (int ch = 0; ch < NCH; ch++) begin
            for (int i = 0; i < KK*KK; i++) begin
                w_we   = 1'b1;
                w_ch   = 1'(ch);
                w_idx  = 4'(i);
                w_data = DW'(wm[ch][i]);
                @(negedge clk);
            end
        end
        w_we = 1'b0;
    endtask

    task automatic clear_model();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = 0;
        for (int ch = 0; ch < NCH; ch++)
            for (int i = 0; i < KK*KK; i++)
                wm[ch][i] = 0;
    endtask

    // Runs one frame from a negedge; returns at the negedge where done should show.
    task automatic run_frame(input bit relu, input int stall_at, input bit gaps, input bit inject);
        logic [NCH*DW:0]   e;
        logic [NCH*DW-1:0] held;
        int  pix, nout, stall_left, cyc;
        bit  lat_pending;
        push_golden(relu);
        held = '0;
        start = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
        pix = 0; nout = 0; stall_left = 5; cyc = 0; lat_pending = 0;
        while (nout < NOUT && cyc < 2000) begin
            if (lat_pending) begin
                chk("latency1", out_valid, 1);
                lat_pending = 0;
            end
            w_we  = 1'b0;
            start = 1'b0;
            if (inject && pix == 5) begin
                w_we = 1'b1; w_ch = 1'b0; w_idx = 4'd0; w_data = DW'(7);
                start = 1'b1; relu_en = ~relu;
            end
            out_ready = 1'b1;
            if (out_valid && nout == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == 5) held = out_data;
                else chk("stall_dat", out_data, held);
                stall_left--;
            end
            in_valid = (pix < NPIX) && (!gaps || $urandom_range(0, 3) != 0);
            in_data  = (pix < NPIX) ? DW'(img[pix / IW][pix % IW]) : '0;
            #1;
            if (!out_ready) chk("stall_in_rdy", in_ready, 0);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("out_dat", out_data, e[NCH*DW-1:0]);
                chk("out_last", out_last, e[NCH*DW]);
                nout++;
            end
            if (in_valid && in_ready) begin
                if (pix == (KK-1)*IW + KK - 1) lat_pending = 1;
                pix++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; w_we = 1'b0; start = 1'b0; relu_en = 1'b0;
        chk("n_out", nout, NOUT);
        chk("n_pix", pix, NPIX);
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
    endtask

    task automatic reset_mid_frame();
        int pix, cyc;
        exp_q.delete();
        start = 1'b1; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pix = 0; cyc = 0;
        out_ready = 1'b1;
        while (pix < 20 && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = DW'(img[pix / IW][pix % IW]);
            #1;
            if (in_ready) pix++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("pre_rst_pix", pix, 20);
        chk("pre_rst_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; relu_en = 1'b0;
        w_we = 1'b0; w_ch = '0; w_idx = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_in_ready0", in_ready, 0);
        chk("rst_out_valid0", out_valid, 0);
        chk("rst_out_last0", out_last, 0);
        chk("rst_out_data0", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse response.
        clear_model();
        img[0][0] = 1; wm[0][0] = 1;
        load_weights();
        run_frame(0, -1, 0, 0);

        // Identity via centre tap on channel 1, with random input gaps.
        clear_model();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = r * IW + c;
        wm[1][4] = 1;
        load_weights();
        run_frame(0, -1, 1, 0);

        // Saturation both directions, then with ReLU.
        clear_model();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = 200;
        for (int i = 0; i < KK*KK; i++) begin
            wm[0][i] = 200;
            wm[1][i] = -200;
        end
        load_weights();
        run_frame(0, -1, 0, 0);
        run_frame(1, -1, 0, 0);

        // Random signed data, then the same frame under back-pressure.
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = int'($urandom_range(0, 200)) - 100;
        for (int ch = 0; ch < NCH; ch++)
            for (int i = 0; i < KK*KK; i++)
                wm[ch][i] = int'($urandom_range(0, 100)) - 50;
        load_weights();
        run_frame(0, -1, 0, 0);
        run_frame(0, 3, 0, 0);

        // Weight write and start during RUN are ignored; next frame unchanged.
        run_frame(0, -1, 0, 1);
        run_frame(0, -1, 0, 0);

        // Reset mid-frame, then a clean frame with persisting weights.
        reset_mid_frame();
        run_frame(0, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
